bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble converter: WIDTH-bit unsigned binary in, eight packed BCD digits out.
- Sits directly upstream of the 8-digit multiplexed seven-segment display driver. Its Dis0..Dis7 outputs wire 1:1 to the display's digit inputs; Dis0 is the units digit (rightmost display).
- Performs one shift per clock, so a full conversion takes WIDTH cycles.
- Digit outputs are registered and hold the last result, so the display never shows intermediate values.

Parameters:
- WIDTH, 27, binary input width. Range 4..27. 27 bits is the minimum width covering 99,999,999.
- ANCHO, 4, digit width. Fixed at 4; exists only for port compatibility with the display driver.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- start  input  1  conversion request, sampled only in IDLE.
- Bin  input  WIDTH  unsigned binary value, captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; Dis0..Dis7 and ovf are updated in the same cycle.
- ovf  output  1  last conversion exceeded 99,999,999.
- Dis0..Dis7  output  ANCHO each  BCD digits; Dis0 is least significant, Dis7 most significant.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, ovf=0, all Dis*=0.
  - Shift register, scratch BCD and counter cleared.
  - Applies immediately, including mid-conversion; the partial result is discarded.
- States: IDLE, SHIFT.
- IDLE, edge with start=1:
  - Load Bin into shift register; clear 32-bit scratch, counter and sticky overflow.
  - Go to SHIFT; busy=1 from this edge.
- SHIFT, every edge:
  - Step 1: every scratch nibble >=5 gets +3 (all nibbles in parallel, 4-bit, no carry between nibbles).
  - Step 2: shift {scratch, shiftreg} left by 1. Shiftreg MSB enters scratch bit 0; scratch bit 31 is shifted out.
  - Overflow: a 1 shifted out of bit 31, or any corrected nibble >9 after the final shift, sets sticky overflow.
  - Counter increments each shift.
- Final shift (counter==WIDTH-1):
  - Latch the post-shift scratch into Dis0..Dis7.
  - Latch ovf; if overflow, force all Dis*=4'd9.
  - done=1 for exactly the next cycle; busy=0; return to IDLE.
- Latency: done is high in the cycle starting WIDTH edges after the start-accepting edge. busy is high for exactly WIDTH cycles.
- start while busy: ignored, no queueing. Changes on Bin while busy: ignored.
- start held high: after done, one IDLE cycle, then a new conversion is accepted on the next edge. Throughput is one result per WIDTH+1 cycles.
- Outputs and ovf hold until the next done or reset.
- Overflow reachability: for WIDTH<=26, ovf can never assert (2^26-1 < 10^8).
- Outputs are always valid BCD (0..9) for downstream decoding.

Test Plan:
- Reset, then start with Bin=0 -> busy high 27 cycles, done pulse on cycle 27, all Dis=0, ovf=0.
- Bin=12345678 -> Dis7..Dis0 = 1,2,3,4,5,6,7,8, ovf=0. Also Bin=9 -> Dis0=9, others 0.
- Bin=99,999,999 -> all digits 9, ovf=0. Then Bin=100,000,000 -> ovf=1, all digits 9. Then Bin=134,217,727 -> ovf=1.
- Start Bin=42; pulse start with Bin=777 at cycle 10 -> second request ignored, result Dis1=4, Dis0=2, single done pulse.
- Complete Bin=5555, then start Bin=1000 and assert rst at cycle 13 -> Dis*, busy, done, ovf all 0 immediately, no done pulse. After release, start Bin=1000 -> Dis3=1, other digits 0.
- start held high with Bin stepping 0,1,2 -> done pulses every 28 cycles with results 0,1,2 and no missed or duplicated conversion.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: WIDTH-bit unsigned binary to eight BCD digits,
// one shift per clock, with registered digit outputs that hold the last result.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned ANCHO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [ANCHO-1:0] Dis0,
    output logic [ANCHO-1:0] Dis1,
    output logic [ANCHO-1:0] Dis2,
    output logic [ANCHO-1:0] Dis3,
    output logic [ANCHO-1:0] Dis4,
    output logic [ANCHO-1:0] Dis5,
    output logic [ANCHO-1:0] Dis6,
    output logic [ANCHO-1:0] Dis7
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [31:0]      dis_q, dis_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [31:0] corrected;
    logic [31:0] scratch_shift;
    logic        carry_out;
    logic        bad_nib;
    logic        final_ovf;

    // Add-3 correction on every nibble in parallel, then shift the combined register.
    always_comb begin
        corrected = '0;
        bad_nib   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            corrected[4*i +: 4] = scratch_q[4*i +: 4] +
                                  ((scratch_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
        scratch_shift = {corrected[30:0], shift_q[WIDTH-1]};
        carry_out     = corrected[31];
        for (int i = 0; i < 8; i++) begin
            if (scratch_shift[4*i +: 4] > 4'd9) bad_nib = 1'b1;
        end
        final_ovf = ovf_acc_q | carry_out | bad_nib;
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        dis_d     = dis_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = Bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                shift_d   = shift_q << 1;
                scratch_d = scratch_shift;
                cnt_d     = cnt_q + 1'b1;
                ovf_acc_d = ovf_acc_q | carry_out;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    ovf_d   = final_ovf;
                    // Saturate to all nines so the display never shows a truncated value.
                    dis_d   = final_ovf ? 32'h9999_9999 : scratch_shift;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            dis_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            dis_q     <= dis_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == StShift);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign Dis0 = dis_q[3:0];
    assign Dis1 = dis_q[7:4];
    assign Dis2 = dis_q[11:8];
    assign Dis3 = dis_q[15:12];
    assign Dis4 = dis_q[19:16];
    assign Dis5 = dis_q[23:20];
    assign Dis6 = dis_q[27:24];
    assign Dis7 = dis_q[31:28];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed and random values against a
// decimal arithmetic reference, plus latency, ignored start, reset and streaming.
module tb_bin_to_bcd_seq;

    localparam int W = 27;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  Bin = '0;
    logic          busy, done, ovf;
    logic [3:0]    Dis0, Dis1, Dis2, Dis3, Dis4, Dis5, Dis6, Dis7;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.WIDTH(W), .ANCHO(4)) dut (
        .clk(clk), .rst(rst), .start(start), .Bin(Bin),
        .busy(busy), .done(done), .ovf(ovf),
        .Dis0(Dis0), .Dis1(Dis1), .Dis2(Dis2), .Dis3(Dis3),
        .Dis4(Dis4), .Dis5(Dis5), .Dis6(Dis6), .Dis7(Dis7)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] digits();
        return {Dis7, Dis6, Dis5, Dis4, Dis3, Dis2, Dis1, Dis0};
    endfunction

    // Reference: decimal digits by division; values beyond eight digits saturate to nines.
    function automatic logic [31:0] ref_digits(input longint v);
        logic [31:0] r = '0;
        longint      x = v;
        if (v > 64'd99999999) return 32'h9999_9999;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint v);
        return v > 64'd99999999;
    endfunction

    // Runs one conversion; lat = negedges after the accepting edge until done, -1 on timeout.
    task automatic convert(input logic [W-1:0] v, output int lat, output int busy_cycles,
                           output int done_count);
        lat = -1;
        busy_cycles = 0;
        done_count = 0;
        @(negedge clk);
        Bin = v;
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                if (lat < 0) lat = n - 1;
            end
            if (lat >= 0 && n >= lat + 4) break;
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL convert_timeout: value %0d gave no done within 60 cycles", v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, ovf, digits()} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b ovf=%b dis=%h, want all 0",
                     busy, done, ovf, digits());
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_latency();
        int lat, bc, dc;
        convert('0, lat, bc, dc);
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL zero_latency: got %0d, want %0d", lat, W);
        end
        checks++;
        if (bc !== W) begin
            errors++;
            $display("FAIL zero_busy_cycles: got %0d, want %0d", bc, W);
        end
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL zero_done_pulses: got %0d, want 1", dc);
        end
        checks++;
        if ({ovf, digits()} !== 33'd0) begin
            errors++;
            $display("FAIL zero_result: got ovf=%b dis=%h, want 0/00000000", ovf, digits());
        end
    endtask

    task automatic test_directed();
        longint vals[6] = '{12345678, 9, 99999999, 100000000, 134217727, 10000000};
        int lat, bc, dc;
        foreach (vals[i]) begin
            convert(W'(vals[i]), lat, bc, dc);
            checks++;
            if (digits() !== ref_digits(vals[i]) || ovf !== ref_ovf(vals[i])) begin
                errors++;
                $display("FAIL directed_%0d: got ovf=%b dis=%h, want ovf=%b dis=%h", vals[i],
                         ovf, digits(), ref_ovf(vals[i]), ref_digits(vals[i]));
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, dc;
        longint v;
        for (int i = 0; i < 24; i++) begin
            v = (i % 3 == 0) ? longint'($urandom_range(134217727, 0))
                             : longint'($urandom_range(99999999, 0));
            convert(W'(v), lat, bc, dc);
            checks++;
            if (digits() !== ref_digits(v) || ovf !== ref_ovf(v) || lat !== W) begin
                errors++;
                $display("FAIL random_%0d: got ovf=%b dis=%h lat=%0d, want ovf=%b dis=%h lat=%0d",
                         v, ovf, digits(), lat, ref_ovf(v), ref_digits(v), W);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dc = 0;
        @(negedge clk);
        Bin = W'(42);
        start = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            start = (n == 10);
            Bin = (n >= 10 && n <= 12) ? W'(777) : W'(42);
            if (done) dc++;
        end
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", dc);
        end
        checks++;
        if (digits() !== ref_digits(42) || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_result: got dis=%h ovf=%b, want %h/0",
                     digits(), ovf, ref_digits(42));
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, dc, seen;
        convert(W'(5555), lat, bc, dc);
        checks++;
        if (digits() !== ref_digits(5555)) begin
            errors++;
            $display("FAIL pre_reset_result: got %h, want %h", digits(), ref_digits(5555));
        end
        @(negedge clk);
        Bin = W'(1000);
        start = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, ovf, digits()} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b ovf=%b dis=%h, want all 0",
                     busy, done, ovf, digits());
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d busy/done cycles, want 0", seen);
        end
        convert(W'(1000), lat, bc, dc);
        checks++;
        if (digits() !== 32'h0000_1000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_1000: got dis=%h ovf=%b, want 00001000/0", digits(), ovf);
        end
    endtask

    task automatic test_back_to_back();
        int last_done = -1;
        int k = 0;
        int n = 0;
        @(negedge clk);
        Bin = W'(0);
        start = 1'b1;
        while (k < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (done) begin
                checks++;
                if (digits() !== ref_digits(k) || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_result_%0d: got %h, want %h", k, digits(),
                             ref_digits(k));
                end
                if (last_done >= 0) begin
                    checks++;
                    if (n - last_done !== W + 1) begin
                        errors++;
                        $display("FAIL stream_period_%0d: got %0d, want %0d", k,
                                 n - last_done, W + 1);
                    end
                end
                last_done = n;
                k++;
                Bin = W'(k);
            end
        end
        start = 1'b0;
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL stream_count: got %0d results, want 3", k);
        end
        repeat (W + 3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
